// File: rtl/mem_responder.sv
// Word-wide RAM responder for the datapath Read/Write strobes.
// Holds off completion for WAIT_STATES cycles, then pulses Mem_Ready.
module mem_responder #(
  parameter int ADDR_W      = 9,
  parameter int DATA_W      = 32,
  parameter int WAIT_STATES = 1,
  parameter     INIT_FILE   = ""
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              Read,
  input  logic              Write,
  input  logic [ADDR_W-1:0] Address,
  input  logic [DATA_W-1:0] Data_In,
  output logic [DATA_W-1:0] Mdatain,
  output logic              Mem_Ready,
  output logic              Busy,
  output logic              Err
);

  typedef enum logic [1:0] {
    S_IDLE, S_WAIT, S_DONE
  } state_t;

  localparam logic [3:0] WS = 4'(WAIT_STATES);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              op_wr_q, op_wr_d;
  logic [DATA_W-1:0] mdatain_q, mdatain_d;
  logic              err_q, err_d;

  logic              acc_en;
  logic              acc_wr;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_data;
  logic              held;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      op_wr_q   <= 1'b0;
      mdatain_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      op_wr_q   <= op_wr_d;
      mdatain_q <= mdatain_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    data_d   = data_q;
    op_wr_d  = op_wr_q;
    err_d    = 1'b0;
    acc_en   = 1'b0;
    acc_wr   = op_wr_q;
    acc_addr = addr_q;
    acc_data = data_q;
    held     = op_wr_q ? Write : Read;
    unique case (state_q)
      S_IDLE: begin
        if (Read ^ Write) begin
          addr_d  = Address;
          data_d  = Data_In;
          op_wr_d = Write;
          cnt_d   = WS;
          if (WS == 4'd0) begin
            state_d  = S_DONE;
            acc_en   = 1'b1;
            acc_wr   = Write;
            acc_addr = Address;
            acc_data = Data_In;
          end else begin
            state_d = S_WAIT;
          end
        end else if (Read && Write) begin
          err_d = 1'b1;
        end
      end
      S_WAIT: begin
        if (!held) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == 4'd1) begin
          state_d = S_DONE;
          cnt_d   = '0;
          acc_en  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    mdatain_d = (acc_en && !acc_wr)
              ? mem[acc_addr] : mdatain_q;
  end

  always_ff @(posedge clk) begin
    if (clr && acc_en && acc_wr) begin
      mem[acc_addr] <= acc_data;
    end
  end

  always_comb begin
    Mem_Ready = (state_q == S_DONE);
    Busy      = (state_q != S_IDLE);
    Mdatain   = mdatain_q;
    Err       = err_q;
  end

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder at WAIT_STATES = 1, 3 and 0.
// Instance index 0 -> 1 wait, 1 -> 3 waits, 2 -> 0 waits.
module tb_mem_responder;

    logic        clk;
    logic        clr;
    logic        rd   [3];
    logic        wr   [3];
    logic [8:0]  ad   [3];
    logic [31:0] di   [3];
    logic [31:0] mdo  [3];
    logic        rdy  [3];
    logic        bsy  [3];
    logic        err  [3];

    logic [31:0] model [3][512];
    logic [31:0] exp_q [$];
    int          checks;
    int          failures;

    mem_responder #(.WAIT_STATES(1)) u_ws1 (
        .clk(clk), .clr(clr), .Read(rd[0]), .Write(wr[0]),
        .Address(ad[0]), .Data_In(di[0]), .Mdatain(mdo[0]),
        .Mem_Ready(rdy[0]), .Busy(bsy[0]), .Err(err[0])
    );

    mem_responder #(.WAIT_STATES(3)) u_ws3 (
        .clk(clk), .clr(clr), .Read(rd[1]), .Write(wr[1]),
        .Address(ad[1]), .Data_In(di[1]), .Mdatain(mdo[1]),
        .Mem_Ready(rdy[1]), .Busy(bsy[1]), .Err(err[1])
    );

    mem_responder #(.WAIT_STATES(0)) u_ws0 (
        .clk(clk), .clr(clr), .Read(rd[2]), .Write(wr[2]),
        .Address(ad[2]), .Data_In(di[2]), .Mdatain(mdo[2]),
        .Mem_Ready(rdy[2]), .Busy(bsy[2]), .Err(err[2])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drives one request, waits (bounded) for Mem_Ready, drops the strobe
    // in the DONE cycle. lat = negedges from capture to Mem_Ready, 0 = timeout.
    task automatic access(input int i, input bit w, input logic [8:0] a,
                          input logic [31:0] d, output int lat,
                          output logic [31:0] dout);
        @(negedge clk);
        rd[i] = ~w;
        wr[i] = w;
        ad[i] = a;
        di[i] = d;
        if (!w) exp_q.push_back(model[i][a]);
        lat  = 0;
        dout = '0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (rdy[i]) begin
                lat  = k;
                dout = mdo[i];
                break;
            end
        end
        rd[i] = 1'b0;
        wr[i] = 1'b0;
        if (w && lat != 0) model[i][a] = d;
    endtask

    task automatic test_reset;
        clr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rd[i] = 1'b0;
            wr[i] = 1'b0;
            ad[i] = '0;
            di[i] = '0;
        end
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({mdo[i], rdy[i], bsy[i], err[i]} !== 35'd0) begin
                failures++;
                $display("FAIL reset_outputs inst=%0d got mdo=%h rdy=%b bsy=%b err=%b want all 0",
                         i, mdo[i], rdy[i], bsy[i], err[i]);
            end
        end
        clr = 1'b1;
    endtask

    task automatic test_read_latency;
        int lat;
        logic [31:0] dout, e;
        access(0, 1'b1, 9'h075, 32'h1234_5678, lat, dout);
        checks++;
        if (lat != 2) begin
            failures++;
            $display("FAIL write_latency_ws1 got %0d want 2", lat);
        end
        @(negedge clk);
        rd[0] = 1'b1;
        ad[0] = 9'h075;
        exp_q.push_back(model[0][9'h075]);
        @(negedge clk);
        checks++;
        if ({bsy[0], rdy[0]} !== 2'b10) begin
            failures++;
            $display("FAIL read_cycle1 got busy/rdy=%b want 10", {bsy[0], rdy[0]});
        end
        ad[0] = 9'h000;
        @(negedge clk);
        checks++;
        if ({bsy[0], rdy[0]} !== 2'b11) begin
            failures++;
            $display("FAIL read_cycle2 got busy/rdy=%b want 11", {bsy[0], rdy[0]});
        end
        e = exp_q.pop_front();
        checks++;
        if (mdo[0] !== e) begin
            failures++;
            $display("FAIL read_data_075 got %h want %h", mdo[0], e);
        end
        rd[0] = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({bsy[0], rdy[0], mdo[0]} !== {2'b00, 32'h1234_5678}) begin
            failures++;
            $display("FAIL read_hold got busy/rdy=%b mdo=%h want 00 12345678",
                     {bsy[0], rdy[0]}, mdo[0]);
        end
    endtask

    task automatic test_write_read;
        int lat;
        logic [31:0] dout, e;
        access(0, 1'b1, 9'h0A3, 32'hDEAD_BEEF, lat, dout);
        checks++;
        if (dout !== 32'h1234_5678 || lat != 2) begin
            failures++;
            $display("FAIL mdatain_during_write got %h lat=%0d want 12345678 lat=2", dout, lat);
        end
        access(0, 1'b0, 9'h0A3, 32'h0, lat, dout);
        e = exp_q.pop_front();
        checks++;
        if (dout !== e || lat != 2) begin
            failures++;
            $display("FAIL raw_0a3 got %h lat=%0d want %h lat=2", dout, lat, e);
        end
    endtask

    task automatic test_err;
        int lat;
        logic [31:0] dout, e;
        @(negedge clk);
        rd[0] = 1'b1;
        wr[0] = 1'b1;
        ad[0] = 9'h075;
        di[0] = 32'hFFFF_0000;
        @(negedge clk);
        checks++;
        if ({err[0], bsy[0], rdy[0]} !== 3'b100) begin
            failures++;
            $display("FAIL err_pulse got err/busy/rdy=%b want 100", {err[0], bsy[0], rdy[0]});
        end
        rd[0] = 1'b0;
        wr[0] = 1'b0;
        @(negedge clk);
        checks++;
        if ({err[0], bsy[0]} !== 2'b00) begin
            failures++;
            $display("FAIL err_one_cycle got err/busy=%b want 00", {err[0], bsy[0]});
        end
        access(0, 1'b0, 9'h075, 32'h0, lat, dout);
        e = exp_q.pop_front();
        checks++;
        if (dout !== e) begin
            failures++;
            $display("FAIL err_no_write got %h want %h", dout, e);
        end
    endtask

    task automatic test_back_to_back;
        int lat, nrdy;
        logic [31:0] dout, e;
        @(negedge clk);
        rd[0] = 1'b1;
        ad[0] = 9'h0A3;
        exp_q.push_back(model[0][9'h0A3]);
        nrdy = 0;
        for (int k = 0; k < 10 && nrdy == 0; k++) begin
            @(negedge clk);
            if (rdy[0]) nrdy++;
        end
        e = exp_q.pop_front();
        checks++;
        if (nrdy != 1 || mdo[0] !== e) begin
            failures++;
            $display("FAIL held_first got rdy=%0d mdo=%h want 1 %h", nrdy, mdo[0], e);
        end
        @(negedge clk);
        checks++;
        if ({bsy[0], rdy[0]} !== 2'b00) begin
            failures++;
            $display("FAIL held_not_reaccepted got busy/rdy=%b want 00", {bsy[0], rdy[0]});
        end
        rd[0] = 1'b0;
        nrdy = 0;
        repeat (4) begin
            @(negedge clk);
            if (rdy[0] || bsy[0]) nrdy++;
        end
        checks++;
        if (nrdy != 0) begin
            failures++;
            $display("FAIL held_extra_ready got %0d want 0", nrdy);
        end
        access(0, 1'b0, 9'h075, 32'h0, lat, dout);
        e = exp_q.pop_front();
        checks++;
        if (dout !== e || lat != 2) begin
            failures++;
            $display("FAIL reraise got %h lat=%0d want %h lat=2", dout, lat, e);
        end
    endtask

    task automatic test_abort_reset;
        int lat, nrdy;
        logic [31:0] dout, e;
        access(1, 1'b1, 9'h010, 32'hAAAA_5555, lat, dout);
        checks++;
        if (lat != 4) begin
            failures++;
            $display("FAIL write_latency_ws3 got %0d want 4", lat);
        end
        @(negedge clk);
        wr[1] = 1'b1;
        ad[1] = 9'h010;
        di[1] = 32'h0BAD_F00D;
        @(negedge clk);
        wr[1] = 1'b0;
        nrdy = 0;
        repeat (6) begin
            @(negedge clk);
            if (rdy[1] || bsy[1]) nrdy++;
        end
        checks++;
        if (nrdy != 0) begin
            failures++;
            $display("FAIL abort_activity got %0d want 0", nrdy);
        end
        access(1, 1'b0, 9'h010, 32'h0, lat, dout);
        e = exp_q.pop_front();
        checks++;
        if (dout !== e || lat != 4) begin
            failures++;
            $display("FAIL abort_no_write got %h lat=%0d want %h lat=4", dout, lat, e);
        end
        @(negedge clk);
        rd[1] = 1'b1;
        ad[1] = 9'h010;
        @(negedge clk);
        clr   = 1'b0;
        rd[1] = 1'b0;
        #1;
        checks++;
        if ({mdo[1], bsy[1], rdy[1]} !== 34'd0) begin
            failures++;
            $display("FAIL midop_reset got mdo=%h busy=%b rdy=%b want 0 0 0",
                     mdo[1], bsy[1], rdy[1]);
        end
        @(negedge clk);
        clr  = 1'b1;
        nrdy = 0;
        repeat (6) begin
            @(negedge clk);
            if (rdy[1]) nrdy++;
        end
        checks++;
        if (nrdy != 0) begin
            failures++;
            $display("FAIL ready_after_reset got %0d want 0", nrdy);
        end
    endtask

    task automatic test_zero_wait;
        int lat;
        logic [31:0] dout, e;
        logic [9:0] mar;
        access(2, 1'b1, 9'h1FF, 32'hCAFE_F00D, lat, dout);
        access(2, 1'b0, 9'h1FF, 32'h0, lat, dout);
        e = exp_q.pop_front();
        checks++;
        if (dout !== e || lat != 1) begin
            failures++;
            $display("FAIL ws0_read_1ff got %h lat=%0d want %h lat=1", dout, lat, e);
        end
        mar = 10'h200;
        access(2, 1'b1, mar[8:0], 32'h600D_CAFE, lat, dout);
        mar = 10'h000;
        access(2, 1'b0, mar[8:0], 32'h0, lat, dout);
        e = exp_q.pop_front();
        checks++;
        if (dout !== e || lat != 1) begin
            failures++;
            $display("FAIL ws0_wrap got %h lat=%0d want %h lat=1", dout, lat, e);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_read_latency();
        test_write_read();
        test_err();
        test_back_to_back();
        test_abort_reset();
        test_zero_wait();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_leftover got %0d want 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
